// File: rtl/branch_predictor.sv
// Fetch-side dynamic branch predictor: direct-mapped 2-bit counter table with branch target buffer.
// Optional execute-stage statistics counters are enabled by defining BRANCH_PREDICTOR_STATS_EN.
module branch_predictor #(
    parameter int unsigned INDEX_BITS = 6
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] PC_F,
    output logic        Predict_Taken_F,
    output logic [31:0] Predict_Target_F,
    input  logic        Branch_E,
    input  logic        Branch_Taken_E,
    input  logic [31:0] PC_E,
    input  logic [31:0] Branch_Target_E
`ifdef BRANCH_PREDICTOR_STATS_EN
    ,
    input  logic        Predict_Taken_E,
    output logic [31:0] Branch_Count,
    output logic [31:0] Mispredict_Count
`endif
);

    localparam int unsigned TAG_BITS = 30 - INDEX_BITS;
    localparam int unsigned ENTRIES  = 1 << INDEX_BITS;

    logic [ENTRIES-1:0]       valid_q;
    logic [ENTRIES-1:0][1:0]  ctr_q;
    logic [TAG_BITS-1:0]      tag_q    [ENTRIES];
    logic [31:0]              target_q [ENTRIES];

    logic [INDEX_BITS-1:0] idx_f;
    logic [INDEX_BITS-1:0] idx_e;
    logic [TAG_BITS-1:0]   tag_f;
    logic [TAG_BITS-1:0]   tag_e;
    logic                  hit_f;
    logic                  hit_e;
    logic [1:0]            ctr_e;
    logic [1:0]            ctr_inc;
    logic [1:0]            ctr_dec;
    logic                  unused_pc_bits;

    assign idx_f = PC_F[INDEX_BITS+1:2];
    assign tag_f = PC_F[31:INDEX_BITS+2];
    assign idx_e = PC_E[INDEX_BITS+1:2];
    assign tag_e = PC_E[31:INDEX_BITS+2];

    // Byte-offset bits never participate in index or tag.
    assign unused_pc_bits = ^{PC_F[1:0], PC_E[1:0]};

    // Zero-latency lookup; an update on the same edge is not bypassed.
    assign hit_f            = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    assign Predict_Taken_F  = hit_f && ctr_q[idx_f][1];
    assign Predict_Target_F = Predict_Taken_F ? target_q[idx_f] : 32'h0;

    assign hit_e   = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
    assign ctr_e   = ctr_q[idx_e];
    assign ctr_inc = (ctr_e == 2'b11) ? 2'b11 : ctr_e + 2'd1;
    assign ctr_dec = (ctr_e == 2'b00) ? 2'b00 : ctr_e - 2'd1;

    // Valid bits and counters: reset to invalid / weakly-not-taken.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            valid_q <= '0;
            ctr_q   <= {ENTRIES{2'b01}};
        end else if (Branch_E) begin
            if (hit_e) begin
                ctr_q[idx_e] <= Branch_Taken_E ? ctr_inc : ctr_dec;
            end else if (Branch_Taken_E) begin
                valid_q[idx_e] <= 1'b1;
                ctr_q[idx_e]   <= 2'b10;
            end
        end
    end

    // Tag and target are only meaningful behind a valid bit, so they carry no reset.
    always_ff @(posedge CLK) begin
        if (Branch_E && Branch_Taken_E) begin
            tag_q[idx_e]    <= tag_e;
            target_q[idx_e] <= Branch_Target_E;
        end
    end

`ifdef BRANCH_PREDICTOR_STATS_EN
    logic [31:0] branch_count_q;
    logic [31:0] mispredict_count_q;

    // Saturating resolution statistics.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            branch_count_q     <= 32'h0;
            mispredict_count_q <= 32'h0;
        end else if (Branch_E) begin
            if (branch_count_q != 32'hFFFF_FFFF) begin
                branch_count_q <= branch_count_q + 32'd1;
            end
            if ((Branch_Taken_E != Predict_Taken_E) && (mispredict_count_q != 32'hFFFF_FFFF)) begin
                mispredict_count_q <= mispredict_count_q + 32'd1;
            end
        end
    end

    assign Branch_Count     = branch_count_q;
    assign Mispredict_Count = mispredict_count_q;
`endif

endmodule
